// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 memory-port arbiter.
// Holds the arbiter FSM states, the owner encoding and the default starvation limit.
package mips32_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    localparam int STARVE_LIM_DEF = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants made while the fetch port was also waiting.
// force_if rises once that streak reaches STARVE_LIM, handing the next contested slot to IF.
module mem_arb_starve_ctr
    import mips32_pkg::*;
#(
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic clk1,
    input  logic reset,
    input  logic grant_d,
    input  logic grant_i,
    input  logic i_req,
    output logic force_if
);

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    logic [3:0] r_streak;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk1) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (grant_i || (grant_d && !i_req)) begin
            r_streak <= '0;
        end else if (grant_d && (r_streak != LIM)) begin
            r_streak <= r_streak + 4'd1;
        end
    end

    assign force_if = (r_streak == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache/memory backend between the IF port and the MEM-stage data port.
// One transaction at a time: IDLE picks a winner, WAIT runs the backend handshake, RESP returns data.
module mem_port_arbiter
    import mips32_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic          clk1,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_flush,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    arb_owner_t r_owner;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_cancel;
    logic          r_i_gnt;
    logic          r_d_gnt;
    logic          w_grant_d;
    logic          w_grant_i;
    logic          w_force_if;
    logic          w_resp_i;
    logic          w_resp_d;

    mem_arb_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve_ctr (
        .clk1     (clk1),
        .reset    (reset),
        .grant_d  (w_grant_d),
        .grant_i  (w_grant_i),
        .i_req    (i_req),
        .force_if (w_force_if)
    );

    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_i   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_req && !(i_req && w_force_if)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (i_req) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_ready) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: datapath registers are reset as well, because every output must read 0 out of reset.
    always_ff @(posedge clk1) begin
        if (!reset) begin
            r_owner  <= OWN_IF;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cancel <= 1'b0;
            r_i_gnt  <= 1'b0;
            r_d_gnt  <= 1'b0;
        end else begin
            r_i_gnt <= w_grant_i;
            r_d_gnt <= w_grant_d;
            if (w_grant_d) begin
                r_owner  <= OWN_D;
                r_addr   <= d_addr;
                r_we     <= d_we;
                r_wdata  <= d_wdata;
                r_cancel <= 1'b0;
            end else if (w_grant_i) begin
                r_owner  <= OWN_IF;
                r_addr   <= i_addr;
                r_we     <= 1'b0;
                r_wdata  <= '0;
                r_cancel <= 1'b0;
            end
            // The backend handshake always completes; a flush only hides the IF response.
            if (r_state == S_WAIT) begin
                if (i_flush && (r_owner == OWN_IF)) begin
                    r_cancel <= 1'b1;
                end
                if (m_ready) begin
                    r_rdata <= r_we ? '0 : m_rdata;
                end
            end
        end
    end

    assign w_resp_i = (r_state == S_RESP) && (r_owner == OWN_IF);
    assign w_resp_d = (r_state == S_RESP) && (r_owner == OWN_D);

    assign i_gnt    = r_i_gnt;
    assign d_gnt    = r_d_gnt;
    assign i_rvalid = w_resp_i && !r_cancel && !i_flush;
    assign d_rvalid = w_resp_d;
    assign i_rdata  = i_rvalid ? r_rdata : '0;
    assign d_rdata  = d_rvalid ? r_rdata : '0;

    assign m_req   = (r_state == S_WAIT);
    assign m_we    = m_req && r_we;
    assign m_addr  = m_req ? r_addr : '0;
    assign m_wdata = m_req ? r_wdata : '0;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner sequences,
// and a random run compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LIM = 4;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        i_req, i_flush, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ready, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter dut (
        .clk1     (clk1),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_flush  (i_flush),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rdata  (m_rdata),
        .busy     (busy)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic        we;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          lat;
        int          flush_cyc;
        logic        exp_dwin;
        logic        exp_rv;
        logic        exp_mwe;
        logic [31:0] exp_maddr;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          own_d;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [31:0] data;
        bit          cancel;
    } txn_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
    task automatic cyc_begin();
        @(posedge clk1);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 0; i_addr = 0; i_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        m_ready = 0; m_rdata = 0;
    endtask

    // Leaves the caller in the drive phase of the first cycle the DUT samples in IDLE.
    task automatic do_reset();
        cyc_begin();
        reset = 0;
        clear_inputs();
        cyc_begin();
        reset = 1;
    endtask

    task automatic drain();
        clear_inputs();
        m_ready = 1;
        repeat (4) cyc_begin();
        m_ready = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        do_reset();
        i_req = v.ireq; i_addr = v.iaddr;
        d_req = v.dreq; d_we = v.we; d_addr = v.daddr; d_wdata = v.wdata;
        i_flush = (v.flush_cyc == 0);
        m_ready = 0;
        settle();
        check($sformatf("v%0d_idle_busy", idx), busy, 0);
        for (int c = 1; c <= v.lat + 3; c++) begin
            cyc_begin();
            if (c >= 2) begin
                i_req = 0;
                d_req = 0;
            end
            i_flush = (c == v.flush_cyc);
            m_ready = (c == 1 + v.lat);
            m_rdata = m_ready ? v.mem : 32'hA5A5_5A5A;
            settle();
            if (c == 1) begin
                check($sformatf("v%0d_gnt", idx), {i_gnt, d_gnt}, {!v.exp_dwin, v.exp_dwin});
                check($sformatf("v%0d_maddr", idx), m_addr, v.exp_maddr);
                check($sformatf("v%0d_mwe", idx), m_we, v.exp_mwe);
                check($sformatf("v%0d_mwdata", idx), m_wdata, v.exp_mwdata);
            end
            if (c <= 1 + v.lat) begin
                check($sformatf("v%0d_mreq_wait", idx), m_req, 1);
            end
            if (c == 2 + v.lat) begin
                check($sformatf("v%0d_rvalid", idx), {i_rvalid, d_rvalid},
                      v.exp_dwin ? {1'b0, v.exp_rv} : {v.exp_rv, 1'b0});
                check($sformatf("v%0d_rdata", idx), {i_rdata, d_rdata},
                      v.exp_dwin ? {32'h0, v.exp_rdata} : {v.exp_rdata, 32'h0});
                check($sformatf("v%0d_resp_mreq_busy", idx), {m_req, busy}, 2'b01);
            end
            if (c == 3 + v.lat) begin
                check($sformatf("v%0d_end_idle", idx), {busy, i_rvalid, d_rvalid}, 0);
            end
        end
        drain();
    endtask

    vec_t vecs[10];

    // Reference model state for the random run.
    txn_t t;
    bit   md_wait, md_resp, md_gi, md_gd, n_gi, n_gd;
    int   md_streak;
    bit   last_ig, last_dg;

    initial begin
        logic       seq[$];
        logic       exp_seq[10];
        logic       e_irv, e_drv;
        logic [31:0] e_ird, e_drd;

        reset = 0;
        clear_inputs();

        vecs[0] = '{0, 1, 0, 32'h0,   32'h10,  32'h0,    32'hDEADBEEF, 3, -1, 1, 1, 0, 32'h10,  32'h0,    32'hDEADBEEF};
        vecs[1] = '{0, 1, 1, 32'h0,   32'h20,  32'h5,    32'h77,       0, -1, 1, 1, 1, 32'h20,  32'h5,    32'h0};
        vecs[2] = '{1, 0, 0, 32'h4,   32'h0,   32'h0,    32'h11110000, 1, -1, 0, 1, 0, 32'h4,   32'h0,    32'h11110000};
        vecs[3] = '{1, 1, 0, 32'h100, 32'h200, 32'h0,    32'hCAFE,     0, -1, 1, 1, 0, 32'h200, 32'h0,    32'hCAFE};
        vecs[4] = '{1, 0, 0, 32'h8,   32'h0,   32'h0,    32'h1234,     2,  2, 0, 0, 0, 32'h8,   32'h0,    32'h0};
        vecs[5] = '{1, 0, 0, 32'hC,   32'h0,   32'h0,    32'h5678,     0,  2, 0, 0, 0, 32'hC,   32'h0,    32'h0};
        vecs[6] = '{1, 0, 0, 32'h10,  32'h0,   32'h0,    32'h9ABC,     1,  0, 0, 1, 0, 32'h10,  32'h0,    32'h9ABC};
        vecs[7] = '{0, 1, 0, 32'h0,   32'h44,  32'h0,    32'h4444,     1,  1, 1, 1, 0, 32'h44,  32'h0,    32'h4444};
        vecs[8] = '{1, 0, 0, 32'h18,  32'h0,   32'h0,    32'h1818,     2,  3, 0, 0, 0, 32'h18,  32'h0,    32'h0};
        vecs[9] = '{1, 1, 1, 32'h50,  32'h60,  32'hABCD, 32'hFFFF,     2, -1, 1, 1, 1, 32'h60,  32'hABCD, 32'h0};

        // Reset held for several edges with both ports requesting.
        i_req = 1; i_addr = 32'h44; d_req = 1; d_addr = 32'h40;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) cyc_begin();
            if (c == 4) reset = 1;
            settle();
            if (c >= 1 && c <= 4) begin
                check("rst_ctrl", {i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, busy}, 0);
                check("rst_maddr_wdata", {m_addr, m_wdata}, 0);
                check("rst_rdata", {i_rdata, d_rdata}, 0);
            end
            if (c == 5) check("rst_release_gnt", {i_gnt, d_gnt}, 2'b01);
        end
        drain();

        foreach (vecs[k]) run_vec(k, vecs[k]);

        // Both ports held, zero-wait backend: the fifth contested slot goes to IF.
        exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        do_reset();
        i_req = 1; i_addr = 32'h80; d_req = 1; d_addr = 32'h90; m_ready = 1; m_rdata = 32'h1;
        for (int c = 0; c < 60 && seq.size() < 10; c++) begin
            if (c > 0) cyc_begin();
            settle();
            if (d_gnt) seq.push_back(1'b1);
            if (i_gnt) seq.push_back(1'b0);
        end
        check("starve_grant_count", seq.size(), 10);
        for (int k = 0; k < 10 && k < seq.size(); k++) begin
            check($sformatf("starve_order_%0d", k), seq[k], exp_seq[k]);
        end
        drain();

        // Flushed fetch followed by a normal load, no reset in between.
        do_reset();
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) cyc_begin();
            case (c)
                0: begin i_req = 1; i_addr = 32'h4; end
                1: begin i_flush = 1; m_ready = 0; end
                2: begin i_req = 0; i_flush = 0; m_ready = 1; m_rdata = 32'hBAD; end
                4: begin d_req = 1; d_we = 0; d_addr = 32'h30; m_rdata = 32'h600D; end
                6: d_req = 0;
                default: ;
            endcase
            settle();
            if (c == 1) check("flush_ifgnt_maddr", {i_gnt, m_req, m_addr}, {2'b11, 32'h4});
            if (c == 3) check("flush_resp_suppressed", {i_rvalid, i_rdata, busy}, {1'b0, 32'h0, 1'b1});
            if (c == 4) check("flush_busy_drop", busy, 0);
            if (c == 5) check("flush_next_dgnt", {i_gnt, d_gnt, m_addr}, {2'b01, 32'h30});
            if (c == 6) check("flush_next_dresp", {d_rvalid, d_rdata}, {1'b1, 32'h600D});
            if (c == 7) check("flush_next_idle", busy, 0);
        end
        drain();

        // Reset during WAIT with the streak at its limit; streak must restart from 0.
        do_reset();
        i_req = 1; i_addr = 32'hA0; d_req = 1; d_addr = 32'hB0; m_ready = 1; m_rdata = 32'h2;
        for (int c = 0; c <= 25; c++) begin
            if (c > 0) cyc_begin();
            if (c == 10) m_ready = 0;
            if (c == 11) reset = 0;
            if (c == 12) begin reset = 1; m_ready = 1; end
            settle();
            if (c == 10) check("rmid_4th_dgnt", {i_gnt, d_gnt}, 2'b01);
            if (c == 11) check("rmid_wait_mreq", m_req, 1);
            if (c == 12) check("rmid_dropped", {m_req, busy, i_rvalid, d_rvalid}, 0);
            if (c == 13) check("rmid_first_gnt_d", {i_gnt, d_gnt, d_rvalid}, 3'b010);
            if (c == 22) check("rmid_4th_after_d", {i_gnt, d_gnt}, 2'b01);
            if (c == 25) check("rmid_5th_after_i", {i_gnt, d_gnt}, 2'b10);
        end
        drain();

        // Random traffic against the reference model.
        do_reset();
        md_wait = 0; md_resp = 0; md_gi = 0; md_gd = 0; md_streak = 0;
        last_ig = 0; last_dg = 0;
        t = '{0, 0, 0, 0, 0, 0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) cyc_begin();
            if (!i_req) begin
                if ($urandom_range(0, 1) == 1) begin i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC; end
            end else if (last_ig) begin
                i_req = 1'($urandom_range(0, 1)); i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req) begin
                if ($urandom_range(0, 1) == 1) begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
                end
            end else if (last_dg) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            i_flush = ($urandom_range(0, 6) == 0);
            m_ready = ($urandom_range(0, 2) == 0);
            m_rdata = $urandom;
            settle();

            e_irv = md_resp && !t.own_d && !t.cancel && !i_flush;
            e_drv = md_resp && t.own_d;
            e_ird = e_irv ? t.data : 32'h0;
            e_drd = e_drv ? t.data : 32'h0;
            check("rnd_gnt", {i_gnt, d_gnt}, {md_gi, md_gd});
            check("rnd_rvalid", {i_rvalid, d_rvalid}, {e_irv, e_drv});
            check("rnd_rdata", {i_rdata, d_rdata}, {e_ird, e_drd});
            check("rnd_mctrl", {m_req, m_we, busy}, {md_wait, md_wait && t.we, md_wait || md_resp});
            check("rnd_maddr_wdata", {m_addr, m_wdata},
                  md_wait ? {t.addr, t.wdata} : 64'h0);
            last_ig = i_gnt;
            last_dg = d_gnt;

            n_gi = 0;
            n_gd = 0;
            if (md_resp) begin
                md_resp = 0;
            end else if (md_wait) begin
                if (!t.own_d && i_flush) t.cancel = 1;
                if (m_ready) begin
                    t.data  = t.we ? 32'h0 : m_rdata;
                    md_wait = 0;
                    md_resp = 1;
                end
            end else if (d_req && !(i_req && md_streak == LIM)) begin
                t = '{1, d_addr, d_we, d_wdata, 32'h0, 0};
                md_wait = 1;
                n_gd = 1;
                md_streak = i_req ? ((md_streak + 1 > LIM) ? LIM : md_streak + 1) : 0;
            end else if (i_req) begin
                t = '{0, i_addr, 0, 32'h0, 32'h0, 0};
                md_wait = 1;
                n_gi = 1;
                md_streak = 0;
            end
            md_gi = n_gi;
            md_gd = n_gd;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
